// File: rtl/tetris_text_pkg.sv
// Shared types and helpers for the 1-bit text bitmap writer path.
//   state_t      : writer FSM states
//   NUM_GLYPHS   : glyphs in the digit font ROM (0..9)
//   bcd_digit_t  : one packed BCD digit
//   max_decimal  : largest value representable in N decimal digits
//   bits_for     : counter width for a 0..n-1 range (never zero)
package tetris_text_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      COPY,
      DRAIN,
      DONE
   } state_t;

   localparam int NUM_GLYPHS = 10;

   typedef logic [3:0] bcd_digit_t;

   function automatic longint unsigned max_decimal(input int digits);
      longint unsigned m;
      m = 1;
      for (int i = 0; i < digits; i++) begin
         m = m * 10;
      end
      return m - 1;
   endfunction

   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary to BCD converter with saturation.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_start      : load i_value and begin (ignored while busy)
//   i_value      : binary input
//   o_busy       : conversion in progress (VALUE_WIDTH cycles)
//   o_done       : high during the final conversion cycle; o_bcd valid from the next cycle
//   o_bcd        : packed BCD, most significant digit in the top nibble
module bin_to_bcd
   import tetris_text_pkg::*;
#(
   parameter int VALUE_WIDTH = 20,
   parameter int NUM_DIGITS  = 6
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [VALUE_WIDTH-1:0]  i_value,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [4*NUM_DIGITS-1:0] o_bcd
);

   localparam int CW = $clog2(VALUE_WIDTH + 1);
   localparam logic [63:0] MAX_VAL = 64'(max_decimal(NUM_DIGITS));
   localparam logic [CW-1:0] LAST_STEP = CW'(VALUE_WIDTH - 1);

   logic [VALUE_WIDTH-1:0]  r_bin;
   logic [4*NUM_DIGITS-1:0] r_bcd;
   logic [CW-1:0]           r_cnt;
   logic                    r_busy;
   logic                    r_sat;
   logic [4*NUM_DIGITS-1:0] w_adj;
   logic                    w_unused_msb;

   // Add-3 correction on every digit that would overflow past 9 after the shift.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
         assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                   r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
      end
   endgenerate

   // The top bit only matters for out-of-range values, which are saturated anyway.
   assign w_unused_msb = w_adj[4*NUM_DIGITS-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_sat  <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_bin  <= i_value;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b1;
         r_sat  <= 64'(i_value) > MAX_VAL;
      end else if (r_busy) begin
         r_bcd <= {w_adj[4*NUM_DIGITS-2:0], r_bin[VALUE_WIDTH-1]};
         r_bin <= r_bin << 1;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST_STEP) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == LAST_STEP);
   assign o_bcd  = r_sat ? {NUM_DIGITS{4'h9}} : r_bcd;

endmodule

// File: rtl/score_digit_writer.sv
// Renders an unsigned value as NUM_DIGITS decimal glyphs into a 1-bit text RAM,
// copying glyph pixels from a 1-bit digit font ROM. One request = full field redraw.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   start_in       : request (accepted only when idle), value_in captured then
//   busy_out       : high from cycle after accepted start until done_out
//   done_out       : one-cycle pulse together with the last RAM write
//   font_addr      : font ROM address; font_data returns ROM_LATENCY cycles later
//   wr_en/wr_addr/wr_data : text RAM write port
module score_digit_writer
   import tetris_text_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int DIGIT_W       = 16,
   parameter int DIGIT_H       = 24,
   parameter int VALUE_WIDTH   = 20,
   parameter int ADDR_WIDTH    = 15,
   parameter int FONT_AW       = 13,
   parameter int ROM_LATENCY   = 2,
   parameter int BASE_ADDR     = 0,
   parameter int BLANK_LEADING = 1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   start_in,
   input  logic [VALUE_WIDTH-1:0] value_in,
   output logic                   busy_out,
   output logic                   done_out,
   output logic [FONT_AW-1:0]     font_addr,
   input  logic                   font_data,
   output logic                   wr_en,
   output logic [ADDR_WIDTH-1:0]  wr_addr,
   output logic                   wr_data
);

   localparam int PIXELS = NUM_DIGITS * DIGIT_W * DIGIT_H;
   localparam int RW  = bits_for(DIGIT_H);
   localparam int DW  = bits_for(NUM_DIGITS);
   localparam int CLW = bits_for(DIGIT_W);
   localparam int LW  = bits_for(ROM_LATENCY);
   localparam logic [RW-1:0]  ROW_LAST   = RW'(DIGIT_H - 1);
   localparam logic [DW-1:0]  DIGIT_LAST = DW'(NUM_DIGITS - 1);
   localparam logic [CLW-1:0] COL_LAST   = CLW'(DIGIT_W - 1);
   localparam logic [LW-1:0]  DRAIN_LAST = LW'(ROM_LATENCY - 1);
   localparam logic [FONT_AW-1:0]    GLYPH_SIZE = FONT_AW'(DIGIT_W * DIGIT_H);
   localparam logic [FONT_AW-1:0]    ROW_PITCH  = FONT_AW'(DIGIT_W);
   localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);

   // Parameter sanity: every address sum must fit its port width.
   generate
      if (FONT_AW < $clog2(NUM_GLYPHS * DIGIT_W * DIGIT_H)) begin : g_bad_font_aw
         $error("FONT_AW too narrow for the digit font ROM");
      end
      if (longint'(BASE_ADDR) + longint'(PIXELS) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr_w
         $error("Digit field does not fit in ADDR_WIDTH");
      end
      if (ROM_LATENCY < 1) begin : g_bad_latency
         $error("ROM_LATENCY must be at least 1");
      end
   endgenerate

   state_t r_state, w_state_next;
   logic [RW-1:0]           r_row;
   logic [DW-1:0]           r_digit;
   logic [CLW-1:0]          r_col;
   logic [ADDR_WIDTH-1:0]   r_pix_addr;
   logic [LW-1:0]           r_drain;
   logic [FONT_AW-1:0]      r_font_addr;
   logic                    r_busy, r_done;
   logic                    r_wr_en, r_wr_data;
   logic [ADDR_WIDTH-1:0]   r_wr_addr;
   logic                    r_dl_valid [0:ROM_LATENCY];
   logic                    r_dl_blank [0:ROM_LATENCY];
   logic [ADDR_WIDTH-1:0]   r_dl_addr  [0:ROM_LATENCY];

   logic                    w_accept, w_issue, w_last_pix, w_busy_next, w_done_next;
   logic                    w_bcd_busy, w_bcd_done;
   logic [4*NUM_DIGITS-1:0] w_bcd;
   bcd_digit_t              w_digits [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   w_blank;
   logic                    w_blank_cur;
   bcd_digit_t              w_glyph;
   logic [FONT_AW-1:0]      w_font_addr_cur;

   // A start in the done_out cycle is dropped: r_done is still high then.
   assign w_accept = (r_state == IDLE) && start_in && !r_done;

   bin_to_bcd #(
      .VALUE_WIDTH (VALUE_WIDTH),
      .NUM_DIGITS  (NUM_DIGITS)
   ) u_bcd (
      .i_clk   (clk_in),
      .i_rst   (rst_in),
      .i_start (w_accept),
      .i_value (value_in),
      .o_busy  (w_bcd_busy),
      .o_done  (w_bcd_done),
      .o_bcd   (w_bcd)
   );

   // Digit 0 is the leftmost; a digit is blank only if it and all digits left of it are zero.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign w_digits[gi] = w_bcd[4*(NUM_DIGITS-1-gi) +: 4];
         if (gi == NUM_DIGITS - 1) begin : g_last
            assign w_blank[gi] = 1'b0;
         end else if (gi == 0) begin : g_first
            assign w_blank[gi] = (BLANK_LEADING != 0) && (w_digits[gi] == 4'd0);
         end else begin : g_mid
            assign w_blank[gi] = w_blank[gi-1] && (w_digits[gi] == 4'd0);
         end
      end
   endgenerate

   assign w_blank_cur = w_blank[r_digit];
   assign w_glyph     = w_digits[r_digit];
   assign w_font_addr_cur = w_blank_cur ? '0 :
                            FONT_AW'(w_glyph) * GLYPH_SIZE +
                            FONT_AW'(r_row) * ROW_PITCH + FONT_AW'(r_col);
   assign w_last_pix = (r_row == ROW_LAST) && (r_digit == DIGIT_LAST) && (r_col == COL_LAST);

   // FSM state register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = CONVERT;
         CONVERT: if (w_bcd_done || !w_bcd_busy) w_state_next = COPY;
         COPY:    if (w_last_pix) w_state_next = DRAIN;
         DRAIN:   if (r_drain == DRAIN_LAST) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs; busy/done are registered so done lands on the last write cycle
   always_comb begin
      w_issue     = (r_state == COPY);
      w_busy_next = (w_state_next != IDLE);
      w_done_next = (r_state == DONE);
   end

   // Row-major pixel walk; the RAM address is simply the running linear index.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_row      <= '0;
         r_digit    <= '0;
         r_col      <= '0;
         r_pix_addr <= '0;
         r_drain    <= '0;
      end else begin
         r_drain <= (r_state == DRAIN) ? r_drain + 1'b1 : '0;
         if (!w_issue) begin
            r_row      <= '0;
            r_digit    <= '0;
            r_col      <= '0;
            r_pix_addr <= BASE;
         end else begin
            r_pix_addr <= r_pix_addr + 1'b1;
            if (r_col == COL_LAST) begin
               r_col <= '0;
               if (r_digit == DIGIT_LAST) begin
                  r_digit <= '0;
                  r_row   <= r_row + 1'b1;
               end else begin
                  r_digit <= r_digit + 1'b1;
               end
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   // Font address register (holds when idle) and delay line head
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_font_addr   <= '0;
         r_dl_valid[0] <= 1'b0;
         r_dl_blank[0] <= 1'b0;
         r_dl_addr[0]  <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         if (w_issue) begin
            r_font_addr <= w_font_addr_cur;
         end
         r_dl_valid[0] <= w_issue;
         r_dl_blank[0] <= w_issue & w_blank_cur;
         r_dl_addr[0]  <= w_issue ? r_pix_addr : '0;
         r_busy        <= w_busy_next;
         r_done        <= w_done_next;
      end
   end

   // Stage k holds the pixel whose font_addr was presented k cycles ago;
   // stage ROM_LATENCY lines up with font_data.
   generate
      for (gi = 1; gi <= ROM_LATENCY; gi++) begin : g_delay
         always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
               r_dl_valid[gi] <= 1'b0;
               r_dl_blank[gi] <= 1'b0;
               r_dl_addr[gi]  <= '0;
            end else begin
               r_dl_valid[gi] <= r_dl_valid[gi-1];
               r_dl_blank[gi] <= r_dl_blank[gi-1];
               r_dl_addr[gi]  <= r_dl_addr[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= 1'b0;
      end else begin
         r_wr_en   <= r_dl_valid[ROM_LATENCY];
         r_wr_addr <= r_dl_valid[ROM_LATENCY] ? r_dl_addr[ROM_LATENCY] : '0;
         r_wr_data <= r_dl_valid[ROM_LATENCY] & ~r_dl_blank[ROM_LATENCY] & font_data;
      end
   end

   assign busy_out  = r_busy;
   assign done_out  = r_done;
   assign font_addr = r_font_addr;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_score_digit_writer.sv
module tb_score_digit_writer;

   localparam int N    = 3;
   localparam int W    = 4;
   localparam int H    = 2;
   localparam int VW   = 10;
   localparam int AW   = 15;
   localparam int FAW  = 8;
   localparam int RL   = 2;
   localparam int BASE = 100;
   localparam int PIX  = N * W * H;
   localparam int LAT  = VW + PIX + RL + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]               start_v;
   logic [1:0][VW-1:0]       value_v;
   logic [1:0]               busy_v, done_v, wr_en_v, wr_data_v, font_data_v;
   logic [1:0][FAW-1:0]      font_addr_v;
   logic [1:0][AW-1:0]       wr_addr_v;
   logic [1:0]               rom_p1, rom_p2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wq0[$];
   int wq1[$];
   int done_cnt[2] = '{0, 0};

   // Instance 0 blanks leading zeros, instance 1 does not.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         score_digit_writer #(
            .NUM_DIGITS(N), .DIGIT_W(W), .DIGIT_H(H), .VALUE_WIDTH(VW),
            .ADDR_WIDTH(AW), .FONT_AW(FAW), .ROM_LATENCY(RL),
            .BASE_ADDR(BASE), .BLANK_LEADING(gi == 0 ? 1 : 0)
         ) u_dut (
            .clk_in    (clk),
            .rst_in    (rst),
            .start_in  (start_v[gi]),
            .value_in  (value_v[gi]),
            .busy_out  (busy_v[gi]),
            .done_out  (done_v[gi]),
            .font_addr (font_addr_v[gi]),
            .font_data (font_data_v[gi]),
            .wr_en     (wr_en_v[gi]),
            .wr_addr   (wr_addr_v[gi]),
            .wr_data   (wr_data_v[gi])
         );
      end
   endgenerate

   // Font ROM: glyph g pixel = (col == g%4) ^ (row & 1), two-cycle read.
   function automatic logic rom_bit(input logic [FAW-1:0] a);
      int ai, g, r, c;
      ai = int'(a);
      g  = ai / (W * H);
      r  = (ai % (W * H)) / W;
      c  = ai % W;
      return ((c == g % 4) ? 1'b1 : 1'b0) ^ ((r % 2 == 1) ? 1'b1 : 1'b0);
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         rom_p1[k] <= rom_bit(font_addr_v[k]);
         rom_p2[k] <= rom_p1[k];
      end
   end
   assign font_data_v = rom_p2;

   always @(negedge clk) begin
      if (wr_en_v[0]) wq0.push_back({16'd0, wr_addr_v[0], wr_data_v[0]});
      if (wr_en_v[1]) wq1.push_back({16'd0, wr_addr_v[1], wr_data_v[1]});
      for (int k = 0; k < 2; k++) begin
         if (done_v[k]) done_cnt[k] = done_cnt[k] + 1;
      end
   end

   // Reference: decimal digits of the saturated value, leading-zero blanking,
   // row-major pixel p -> (row, digit, col).
   function automatic logic exp_bit(input int value, input bit blank_lead, input int p);
      int v, row, dig, col, g;
      int d[3];
      bit bl;
      v = (value > 999) ? 999 : value;
      d[0] = v / 100;
      d[1] = (v / 10) % 10;
      d[2] = v % 10;
      row = p / (N * W);
      dig = (p % (N * W)) / W;
      col = p % W;
      g   = d[dig];
      bl  = blank_lead && (dig < 2) && (d[0] == 0) && (dig == 0 || d[1] == 0);
      if (bl) return 1'b0;
      return ((col == g % 4) ? 1'b1 : 1'b0) ^ ((row % 2 == 1) ? 1'b1 : 1'b0);
   endfunction

   function automatic int get_entry(input int k, input int idx);
      return (k == 0) ? wq0[idx] : wq1[idx];
   endfunction

   function automatic int q_size(input int k);
      return (k == 0) ? wq0.size() : wq1.size();
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic run(input int k, input int value, input bit poke_mid, input bit poke_done);
      int q0, d0, t0, sz, e;
      bit got;
      string tag;
      tag = $sformatf("k%0d_v%0d", k, value);
      q0  = q_size(k);
      d0  = done_cnt[k];
      @(negedge clk);
      start_v[k] = 1'b1;
      value_v[k] = VW'(value);
      @(negedge clk);
      start_v[k] = 1'b0;
      t0 = cyc;
      check({tag, "_busy_start"}, busy_v[k], 1);
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (poke_mid && n == 20) begin
            start_v[k] = 1'b1;
            value_v[k] = VW'(111);
         end else begin
            start_v[k] = 1'b0;
         end
         if (done_v[k]) got = 1'b1;
      end
      check({tag, "_done_seen"}, got, 1);
      if (got) check({tag, "_latency"}, cyc - t0, LAT);
      if (poke_done) begin
         start_v[k] = 1'b1;
         value_v[k] = VW'(5);
      end
      @(negedge clk);
      start_v[k] = 1'b0;
      check({tag, "_busy_after_done"}, busy_v[k], 0);
      check({tag, "_done_pulses"}, done_cnt[k] - d0, 1);
      sz = q_size(k) - q0;
      check({tag, "_write_count"}, sz, PIX);
      for (int p = 0; p < PIX && p < sz; p++) begin
         e = get_entry(k, q0 + p);
         check($sformatf("%s_addr%0d", tag, p), e >> 1, BASE + p);
         check($sformatf("%s_data%0d", tag, p), e & 1, exp_bit(value, k == 0, p));
      end
      $display("txn inst=%0d value=%0d writes=%0d checks=%0d failures=%0d", k, value, sz, checks, failures);
   endtask

   initial begin
      start_v = '0;
      value_v = '0;
      repeat (3) @(negedge clk);
      check("rst_wr_en", wr_en_v[0], 0);
      check("rst_busy", busy_v[0], 0);
      check("rst_done", done_v[0], 0);
      check("rst_font_addr", font_addr_v[0], 0);
      check("rst_wr_addr", wr_addr_v[0], 0);
      check("rst_wr_data", wr_data_v[0], 0);
      rst = 1'b0;

      run(0, 507, 1'b0, 1'b0);
      run(0, 7, 1'b0, 1'b0);
      run(0, 0, 1'b0, 1'b0);
      run(1, 0, 1'b0, 1'b0);
      run(0, 1023, 1'b0, 1'b0);
      run(1, 1023, 1'b0, 1'b0);
      run(0, 507, 1'b1, 1'b0);
      run(0, 300, 1'b0, 1'b1);

      // Reset between clock edges while writes are streaming out.
      @(negedge clk);
      start_v[0] = 1'b1;
      value_v[0] = VW'(507);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (20) @(negedge clk);
      check("pre_rst_wr_en", wr_en_v[0], 1);
      check("pre_rst_busy", busy_v[0], 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_wr_en", wr_en_v[0], 0);
      check("async_rst_busy", busy_v[0], 0);
      @(negedge clk);
      rst = 1'b0;
      run(0, 42, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run(int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
